// File: rtl/zip_packet_scheduler_pkg.sv
// Shared types and constants for the round-robin IQ zip packet scheduler.
package zip_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    PAD    = 2'd2
  } sched_state_t;

  localparam int DEFAULT_GROUP = 4;

  // Sample layout: I in the upper half, Q in the lower half.
  localparam int I_MSB = 31;
  localparam int Q_MSB = 15;

endpackage

// File: rtl/zip_packet_scheduler_if.sv
// Bundles the NUM_CH sample inputs and the single packer-side output stream.
interface zip_packet_scheduler_if #(
  parameter int NUM_CH = 2,
  parameter int WIDTH  = 32
) ();

  // AXI-Stream rules on every lane: a beat transfers on a clock edge where
  // tvalid and tready are both high; once tvalid is raised, tdata/tlast stay
  // stable and tvalid stays high until that transfer; tready may toggle freely.
  logic [NUM_CH*WIDTH-1:0] s_tdata;
  logic [NUM_CH-1:0]       s_tlast;
  logic [NUM_CH-1:0]       s_tvalid;
  logic [NUM_CH-1:0]       s_tready;
  logic [WIDTH-1:0]        m_tdata;
  logic                    m_tlast;
  logic                    m_tvalid;
  logic                    m_tready;

  // Scheduler side: consumes the channel lanes, drives the packer lane.
  modport slave (
    input  s_tdata, s_tlast, s_tvalid, m_tready,
    output s_tready, m_tdata, m_tlast, m_tvalid
  );

  // Environment side: sample sources plus the packer.
  modport master (
    output s_tdata, s_tlast, s_tvalid, m_tready,
    input  s_tready, m_tdata, m_tlast, m_tvalid
  );

endinterface

// File: rtl/zip_packet_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester above last_grant, with wrap.
module rr_arbiter #(
  parameter int NUM_CH = 2,
  parameter int GW     = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [GW-1:0]     last_grant,
  output logic [NUM_CH-1:0] onehot,
  output logic [GW-1:0]     bin,
  output logic              valid
);

  int idx;

  always_comb begin
    onehot = '0;
    bin    = '0;
    valid  = 1'b0;
    idx    = 0;
    // k = NUM_CH revisits last_grant itself, so a sole requester may repeat.
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = (int'(last_grant) + k) % NUM_CH;
      if (!valid && req[idx]) begin
        valid       = 1'b1;
        onehot[idx] = 1'b1;
        bin         = GW'(idx);
      end
    end
  end

endmodule

// File: rtl/zip_packet_scheduler.sv
// Packet-granular round-robin scheduler feeding one 4:1 IQ zip packer; pads
// each packet with zero samples so it ends on a complete packed word.
module zip_packet_scheduler
  import zip_sched_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int WIDTH  = 32,
  parameter int GROUP  = DEFAULT_GROUP,
  parameter int CNT_W  = 16,
  parameter int GW     = $clog2(NUM_CH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [NUM_CH-1:0]    ch_mask,
  zip_packet_scheduler_if.slave bus,
  output logic                 busy,
  output logic [GW-1:0]        grant,
  output logic                 pkt_done,
  output logic [CNT_W-1:0]     pad_beats,
  output sched_state_t         state
);

  localparam int CW = (GROUP > 1) ? $clog2(GROUP) : 1;

  sched_state_t      state_q, state_d;
  logic [GW-1:0]     grant_q, last_grant_q;
  logic [NUM_CH-1:0] grant_oh_q;
  logic [CW-1:0]     cnt_q;
  logic [CNT_W-1:0]  pad_q;

  logic [NUM_CH-1:0] req, win_onehot;
  logic [GW-1:0]     win_bin;
  logic              win_valid;

  logic [WIDTH-1:0]  sel_data;
  logic              sel_valid, sel_last, last_slot, m_hs;
  logic [WIDTH-1:0]  out_data;
  logic              out_valid, out_last, done;
  logic [NUM_CH-1:0] out_ready;

  assign req = enable ? (bus.s_tvalid & ch_mask) : '0;

  rr_arbiter #(.NUM_CH(NUM_CH), .GW(GW)) u_arb (
    .req        (req),
    .last_grant (last_grant_q),
    .onehot     (win_onehot),
    .bin        (win_bin),
    .valid      (win_valid)
  );

  assign sel_data  = bus.s_tdata[grant_q*WIDTH +: WIDTH];
  assign sel_valid = bus.s_tvalid[grant_q];
  assign sel_last  = bus.s_tlast[grant_q];
  assign last_slot = (cnt_q == CW'(GROUP - 1));
  assign m_hs      = out_valid & bus.m_tready;

  always_comb begin
    state_d   = state_q;
    out_data  = '0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_ready = '0;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_valid) state_d = STREAM;
      end
      STREAM: begin
        out_data  = sel_data;
        out_valid = sel_valid;
        out_ready = grant_oh_q & {NUM_CH{bus.m_tready}};
        // tlast only survives when the packet already fills the packed word.
        out_last  = sel_valid & sel_last & last_slot;
        if (sel_valid && bus.m_tready && sel_last) begin
          if (last_slot) begin
            done    = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = PAD;
          end
        end
      end
      PAD: begin
        out_valid = 1'b1;
        out_last  = last_slot;
        if (bus.m_tready && last_slot) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(NUM_CH - 1);
      grant_oh_q   <= '0;
      cnt_q        <= '0;
      pad_q        <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && win_valid) begin
        grant_q      <= win_bin;
        last_grant_q <= win_bin;
        grant_oh_q   <= win_onehot;
      end
      // GROUP is a power of two, so natural wrap gives the modulo.
      if (m_hs) cnt_q <= cnt_q + CW'(1);
      if (state_q == PAD && m_hs && pad_q != '1) pad_q <= pad_q + CNT_W'(1);
    end
  end

  assign bus.m_tdata  = out_data;
  assign bus.m_tvalid = out_valid;
  assign bus.m_tlast  = out_last;
  assign bus.s_tready = out_ready;

  assign busy      = (state_q != IDLE);
  assign grant     = grant_q;
  assign pkt_done  = done;
  assign pad_beats = pad_q;
  assign state     = state_q;

endmodule

// File: tb/tb_zip_packet_scheduler.sv
// Randomized bench for zip_packet_scheduler against a packet-level round-robin model.
module tb_zip_packet_scheduler;
  import zip_sched_pkg::*;

  localparam int NUM_CH = 2;
  localparam int WIDTH  = 32;
  localparam int GROUP  = 4;
  localparam int CNT_W  = 16;
  localparam int GW     = $clog2(NUM_CH);

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic              enable;
  logic [NUM_CH-1:0] ch_mask;
  logic              busy;
  logic [GW-1:0]     grant;
  logic              pkt_done;
  logic [CNT_W-1:0]  pad_beats;
  sched_state_t      state;

  zip_packet_scheduler_if #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) bus ();

  zip_packet_scheduler #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .GROUP(GROUP), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .ch_mask   (ch_mask),
    .bus       (bus.slave),
    .busy      (busy),
    .grant     (grant),
    .pkt_done  (pkt_done),
    .pad_beats (pad_beats),
    .state     (state)
  );

  // scoreboard
  int n_checks;
  int n_fail;
  logic [WIDTH:0] exp_q[$];
  int             exp_ch_q[$];
  int             exp_pad;
  int             exp_pkts;
  int             pkt_seen;
  int             out_cnt;

  // sources and model
  logic [WIDTH:0] src_q[NUM_CH][$];
  logic [WIDTH:0] mdl_q[NUM_CH][$];
  bit             first_beat[NUM_CH];
  int             mdl_last;
  int             rdy_pct;
  int             valid_pct;
  bit             mon_en;

  // monitor history
  logic [NUM_CH-1:0] s_hs;
  bit                prev_stall;
  logic [WIDTH:0]    prev_word;
  bit                prev_idle_req;
  bit                prev_done;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic add_packet(input int ch, input int len, input logic [WIDTH-1:0] base, input bit rnd);
    logic [WIDTH-1:0] d;
    for (int b = 0; b < len; b++) begin
      d = rnd ? WIDTH'($urandom) : base + WIDTH'(b);
      src_q[ch].push_back({(b == len - 1), d});
    end
  endtask

  // Packet-level reference: round-robin over masked channels holding queued
  // packets; each packet is padded with zeros to a whole GROUP.
  task automatic build_model();
    logic [WIDTH:0] pkt[$];
    logic [WIDTH:0] b;
    int pick, c, len, pad;
    for (int i = 0; i < NUM_CH; i++) mdl_q[i] = src_q[i];
    while (1) begin
      pick = -1;
      for (int k = 1; k <= NUM_CH; k++) begin
        c = (mdl_last + k) % NUM_CH;
        if (pick < 0 && ch_mask[c] && mdl_q[c].size() > 0) pick = c;
      end
      if (pick < 0) break;
      pkt.delete();
      do begin
        b = mdl_q[pick].pop_front();
        pkt.push_back(b);
      end while (!b[WIDTH]);
      len = pkt.size();
      pad = (GROUP - (len % GROUP)) % GROUP;
      for (int j = 0; j < len; j++) begin
        exp_q.push_back({(j == len - 1) && (pad == 0), pkt[j][WIDTH-1:0]});
        exp_ch_q.push_back(pick);
      end
      for (int j = 0; j < pad; j++) begin
        exp_q.push_back({(j == pad - 1), {WIDTH{1'b0}}});
        exp_ch_q.push_back(100 + pick);
      end
      exp_pad  += pad;
      exp_pkts += 1;
      mdl_last = pick;
    end
  endtask

  // One clock: observe at the falling edge, drive just after the rising edge.
  task automatic cycle();
    logic [WIDTH:0] front;
    logic [WIDTH:0] word;
    int             ec;
    bit             m_hs;
    @(negedge clk);
    m_hs = bus.m_tvalid && bus.m_tready;
    s_hs = bus.s_tvalid & bus.s_tready & {NUM_CH{mon_en}};
    word = {bus.m_tlast, bus.m_tdata};
    if (mon_en) begin
      if (prev_stall) begin
        check("hold_valid", bus.m_tvalid, 1);
        check("hold_word", word, prev_word);
      end
      if (prev_idle_req) check("arb_latency", busy, 1);
      if (prev_done) check("idle_gap", busy, 0);
      for (int i = 0; i < NUM_CH; i++)
        if (bus.s_tready[i]) check("s_tready_owner", i, (exp_ch_q.size() > 0) ? exp_ch_q[0] : -1);
      if (m_hs) begin
        out_cnt++;
        if (exp_q.size() == 0) begin
          check("extra_beat", word, 0);
        end else begin
          check("beat", word, exp_q.pop_front());
          ec = exp_ch_q.pop_front();
          check("beat_grant", grant, ec % 100);
        end
      end
      if (pkt_done || (m_hs && bus.m_tlast)) check("pkt_done", pkt_done, m_hs && bus.m_tlast);
      if (pkt_done) pkt_seen++;
      prev_stall    = bus.m_tvalid && !bus.m_tready;
      prev_word     = word;
      prev_idle_req = !busy && enable && ((bus.s_tvalid & ch_mask) != '0);
      prev_done     = pkt_done;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (s_hs[i]) begin
        front = src_q[i].pop_front();
        first_beat[i] = front[WIDTH];
      end
      if (src_q[i].size() == 0) begin
        bus.s_tvalid[i] = 1'b0;
      end else if (!(bus.s_tvalid[i] && !s_hs[i])) begin
        front = src_q[i][0];
        bus.s_tvalid[i] = first_beat[i] || ($urandom_range(99) < valid_pct);
        bus.s_tdata[i*WIDTH +: WIDTH] = front[WIDTH-1:0];
        bus.s_tlast[i] = front[WIDTH];
      end
    end
    bus.m_tready = ($urandom_range(99) < rdy_pct);
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    mon_en = 1'b0;
    cycle();
    cycle();
    reset = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      src_q[i].delete();
      first_beat[i] = 1'b1;
    end
    bus.s_tvalid = '0;
    bus.s_tlast  = '0;
    bus.s_tdata  = '0;
    exp_q.delete();
    exp_ch_q.delete();
    mdl_last      = NUM_CH - 1;
    exp_pad       = 0;
    exp_pkts      = 0;
    pkt_seen      = 0;
    prev_stall    = 1'b0;
    prev_idle_req = 1'b0;
    prev_done     = 1'b0;
    mon_en        = 1'b1;
    #1;
  endtask

  task automatic reset_checks();
    check("rst_busy", busy, 0);
    check("rst_m_tvalid", bus.m_tvalid, 0);
    check("rst_m_tlast", bus.m_tlast, 0);
    check("rst_m_tdata", bus.m_tdata, 0);
    check("rst_s_tready", bus.s_tready, 0);
    check("rst_pkt_done", pkt_done, 0);
    check("rst_pad_beats", pad_beats, 0);
    check("rst_grant", grant, 0);
    check("rst_state", state, IDLE);
  endtask

  task automatic run_test(input int budget);
    int n;
    build_model();
    n = 0;
    while ((exp_q.size() > 0 || busy) && n < budget) begin
      cycle();
      n++;
    end
    if (n >= budget) check("timeout", 1, 0);
    check("pad_beats", pad_beats, exp_pad);
    check("pkt_count", pkt_seen, exp_pkts);
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    enable       = 1'b1;
    ch_mask      = '1;
    reset        = 1'b1;
    bus.s_tvalid = '0;
    bus.s_tlast  = '0;
    bus.s_tdata  = '0;
    bus.m_tready = 1'b1;
    rdy_pct      = 100;
    valid_pct    = 100;
    out_cnt      = 0;
    do_reset();
    reset_checks();

    // 8-beat packet: no padding, tlast on beat 8
    add_packet(0, 8, 32'h0, 1'b1);
    run_test(200);

    // 5 beats then 3 zero pad beats
    add_packet(0, 5, 32'h11110001, 1'b0);
    run_test(200);

    // single-beat packet: 1 data + 3 pad
    add_packet(1, 1, 32'hABCD1234, 1'b0);
    run_test(200);

    // both channels continuously sending 4-beat packets
    do_reset();
    for (int p = 0; p < 3; p++) begin
      add_packet(0, 4, 32'h00A00000 + 32'(p << 4), 1'b0);
      add_packet(1, 4, 32'h00B00000 + 32'(p << 4), 1'b0);
    end
    run_test(400);

    // ch0 masked out while both request
    ch_mask = 2'b10;
    add_packet(0, 4, 32'h0, 1'b1);
    add_packet(1, 3, 32'h0, 1'b1);
    add_packet(1, 6, 32'h0, 1'b1);
    run_test(400);
    ch_mask = '1;
    do_reset();

    // 6-beat packet under random backpressure and source gaps
    rdy_pct   = 50;
    valid_pct = 70;
    add_packet(0, 6, 32'h0, 1'b1);
    run_test(400);

    // enable low: requests must not be granted
    rdy_pct   = 100;
    valid_pct = 100;
    enable    = 1'b0;
    add_packet(1, 2, 32'h0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("enable_low_idle", busy, 0);
    end
    enable = 1'b1;
    run_test(200);

    // random regression
    for (int it = 0; it < 12; it++) begin
      rdy_pct   = $urandom_range(30, 100);
      valid_pct = $urandom_range(40, 100);
      for (int p = $urandom_range(1, 4); p > 0; p--)
        add_packet($urandom_range(NUM_CH - 1), $urandom_range(1, 10), 32'h0, 1'b1);
      run_test(2000);
    end

    // reset on beat 3 of a 6-beat packet, then ch0 must win first
    rdy_pct   = 100;
    valid_pct = 100;
    do_reset();
    add_packet(0, 6, 32'h0, 1'b1);
    build_model();
    out_cnt = 0;
    for (int n = 0; n < 100 && out_cnt < 3; n++) cycle();
    check("mid_reset_progress", out_cnt, 3);
    do_reset();
    reset_checks();
    add_packet(1, 4, 32'h0, 1'b1);
    add_packet(0, 4, 32'h0, 1'b1);
    run_test(200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/zip_packet_scheduler.md
Name: zip_packet_scheduler

Overview:
- Round-robin, packet-granular arbiter that shares one 4:1 IQ zip packer among NUM_CH AXI-Stream sample channels.
- Input samples are 32-bit, 16-bit I plus 16-bit Q. The packer emits one output word per GROUP input samples.
- Pads every packet with zero samples up to a multiple of GROUP, so each packet ends on a complete packed word carrying tlast.
- Sits between the per-channel sample sources and the packer input inside the QPSK RFNoC block.

Parameters:
- NUM_CH, 2, number of requesting channels (2..8).
- WIDTH, 32, sample width: I in [31:16], Q in [15:0].
- GROUP, 4, samples per packed word; power of two.
- CNT_W, 16, width of the saturating pad-beat statistics counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- enable  in  1  allow new grants
- ch_mask  in  NUM_CH  per-channel grant enable; bit i = channel i
- s_tdata  in  NUM_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- s_tlast  in  NUM_CH  per-channel end of packet
- s_tvalid  in  NUM_CH  per-channel valid
- s_tready  out  NUM_CH  per-channel ready
- m_tdata  out  WIDTH  to packer
- m_tlast  out  1  to packer
- m_tvalid  out  1  to packer
- m_tready  in  1  from packer
- busy  out  1  high in STREAM or PAD
- grant  out  $clog2(NUM_CH)  currently or last granted channel
- pkt_done  out  1  one-cycle pulse on the final beat handshake of each packet
- pad_beats  out  CNT_W  total pad beats inserted; saturates at all-ones

Behaviour:
- Reset values:
  - state = IDLE; s_tready = 0; m_tvalid = 0; m_tlast = 0; m_tdata = 0.
  - busy = 0; pkt_done = 0; pad_beats = 0; sample counter = 0.
  - last_grant = NUM_CH-1, so channel 0 wins first; grant output = 0.
- Reset mid-packet aborts the packet immediately. No pad beats and no tlast are generated.
- IDLE:
  - m_tvalid = 0 and all s_tready = 0.
  - Request vector = s_tvalid & ch_mask, gated by enable.
  - If the request vector is nonzero, the winner is the first requester found searching from last_grant+1 upward with wrap.
  - Register the winner into grant and last_grant, then move to STREAM. Arbitration latency is 1 cycle.
  - enable and ch_mask are sampled only in IDLE.
- STREAM:
  - Pure combinational passthrough of the granted channel:
    - m_tdata = s_tdata[grant]
    - m_tvalid = s_tvalid[grant]
    - s_tready[grant] = m_tready; all other s_tready = 0.
  - Sample counter increments mod GROUP on each m_tvalid & m_tready.
  - On the handshake with s_tlast[grant] = 1:
    - If counter == GROUP-1: m_tlast = 1 on that beat, pkt_done pulses, counter resets to 0, go to IDLE.
    - Otherwise: m_tlast = 0 (suppressed), go to PAD.
  - m_tlast is 0 on all non-final STREAM beats.
- PAD:
  - m_tdata = 0; m_tvalid = 1; all s_tready = 0.
  - Each handshake increments the counter and pad_beats (saturating).
  - On the handshake where counter == GROUP-1: m_tlast = 1, pkt_done pulses, counter resets to 0, go to IDLE.
  - Pad beats per packet = (GROUP - len mod GROUP) mod GROUP, range 0..GROUP-1.
- Deasserting enable or clearing the grant's ch_mask bit mid-packet has no effect. The packet, including its padding, completes.
- m_tready low in any state stalls without loss. m_tdata and m_tlast are held stable while m_tvalid & ~m_tready (AXI-Stream rules).
- No starvation: a continuously requesting masked-in channel is granted within NUM_CH-1 packets.
- Single-beat packet with GROUP = 4 → 1 data beat + 3 pad beats.
- A back-to-back grant of the same channel is permitted only when it is the sole requester.

Decomposition:
- Package zip_sched_pkg: state enum {IDLE, STREAM, PAD}; default GROUP = 4; sample field offsets I_MSB = 31, Q_MSB = 15.
- One sub-module, rr_arbiter: NUM_CH request vector plus last_grant in, one-hot and binary winner out, purely combinational.
- FSM, counter and mux live in the top module.

Test Plan:
- ch0 sends an 8-beat packet, ch1 idle, m_tready = 1 → 8 beats out unchanged; tlast on beat 8; pad_beats = 0; pkt_done pulses once; grant = 0.
- ch0 sends 5 beats with data 0x11110001..0x11110005 → 5 data beats then 3 beats of 0x00000000; tlast only on the 8th beat; pad_beats = 3.
- ch0 and ch1 both continuously send 4-beat packets → grants alternate 0,1,0,1; 1 idle cycle between packets; no beat interleaving within a packet.
- ch_mask = 2'b10 with both channels requesting → only ch1 granted; s_tready[0] stays 0 throughout.
- Random m_tready (50%) on a 6-beat packet → output sequence identical to the m_tready = 1 case (6 data + 2 pad); data held stable during stalls.
- reset asserted on beat 3 of 6 → next cycle m_tvalid = 0, busy = 0, counter = 0; next grant goes to ch0.
